// File: rtl/mux_4_1_rr_arbiter_if.sv
// mux_4_1_rr_arbiter_if: requester/datapath bundle of the round-robin 4:1 mux arbiter; lock exists only with MUX_4_1_RR_ARBITER_LOCK_EN
interface mux_4_1_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       out_valid;
  logic       busy;
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
  logic       lock;
  modport master (output req, data, lock, input gnt, sel, out, out_valid, busy);
  modport slave  (input req, data, lock, output gnt, sel, out, out_valid, busy);
`else
  modport master (output req, data, input gnt, sel, out, out_valid, busy);
  modport slave  (input req, data, output gnt, sel, out, out_valid, busy);
`endif
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter: round-robin arbiter time-sharing a 4:1 one-bit mux; MUX_4_1_RR_ARBITER_LOCK_EN adds a grant lock input
module mux_4_1_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic rst,
  mux_4_1_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  state_t           state;
  logic [1:0]       last;
  logic [1:0]       win;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       mask;
  logic             cur;
  logic             others;
  logic             at_max;
  logic             hold;
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
  assign hold = bus.lock;
`else
  assign hold = 1'b0;
`endif
  // round-robin winner among candidates, scanning from the slot after the last grant
  always_comb begin
    mask   = state == GRANT ? bus.req & ~bus.gnt : bus.req;
    cur    = state == GRANT && bus.req[bus.sel];
    others = |(bus.req & ~bus.gnt);
    at_max = hold_cnt >= CNT_MAX;
    win    = last;
    for (int i = 4; i >= 1; i--)
      if (mask[last + 2'(i)]) win = last + 2'(i);
  end
  // grant sequencing and registered mux output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 2'd3;
      hold_cnt      <= '0;
      bus.gnt       <= '0;
      bus.sel       <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (state == IDLE) begin
      bus.out_valid <= 1'b0;
      if (|bus.req) begin
        bus.gnt  <= 4'b0001 << win;
        bus.sel  <= win;
        last     <= win;
        hold_cnt <= '0;
        state    <= GRANT;
        bus.busy <= 1'b1;
      end
    end else begin
      bus.out       <= bus.data[bus.sel];
      bus.out_valid <= 1'b1;
      if (cur && (hold || !others || !at_max)) begin
        if (!hold && !at_max) hold_cnt <= hold_cnt + 1'b1;
      end else if (others) begin
        bus.gnt  <= 4'b0001 << win;
        bus.sel  <= win;
        last     <= win;
        hold_cnt <= '0;
      end else begin
        bus.gnt  <= '0;
        state    <= IDLE;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb_mux_4_1_rr_arbiter: scoreboard bench for the round-robin 4:1 mux arbiter (MAX_HOLD=4)
module tb_mux_4_1_rr_arbiter;
  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out;
    logic       ov;
    logic       busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];
  exp_t e;
  mux_4_1_rr_arbiter_if bus();
  mux_4_1_rr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.data = '0;
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
    bus.lock = 1'b0;
`endif
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.data = 4'b1111;
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
    bus.lock = 1'b0;
`endif
    for (int k = 0; k < 7; k++) begin
      sb.push_back('{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
      if (k == 1) begin
        rst = 1'b0;
        bus.req = '0;
      end
      if (k == 0) #1; else cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_reset step %0d: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask
  task automatic test_single();
    bus.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      bus.data = 4'($urandom) | 4'b0100;
      if (k == 8) bus.req = '0;
      if (k == 0) sb.push_back('{4'b0100, 2'd2, 1'b0, 1'b0, 1'b1});
      else if (k < 8) sb.push_back('{4'b0100, 2'd2, 1'b1, 1'b1, 1'b1});
      else if (k == 8) sb.push_back('{4'b0000, 2'd2, 1'b1, 1'b1, 1'b0});
      else sb.push_back('{4'b0000, 2'd2, 1'b1, 1'b0, 1'b0});
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_single edge %0d: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask
  task automatic test_rotation();
    logic [3:0] dv;
    int s;
    int p;
    dv = 4'b1010;
    do_reset();
    bus.req = 4'b1111;
    bus.data = dv;
    for (int k = 0; k < 20; k++) begin
      s = (k / 4) % 4;
      p = ((k + 15) / 4) % 4;
      sb.push_back('{4'b0001 << s, 2'(s), k == 0 ? 1'b0 : dv[p], k != 0, 1'b1});
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_rotation edge %0d: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask
  task automatic test_drop_switch();
    do_reset();
    bus.req = 4'b0010;
    bus.data = 4'b0010;
    sb.push_back('{4'b0010, 2'd1, 1'b0, 1'b0, 1'b1});
    sb.push_back('{4'b1000, 2'd3, 1'b1, 1'b1, 1'b1});
    sb.push_back('{4'b0000, 2'd3, 1'b0, 1'b1, 1'b0});
    sb.push_back('{4'b0000, 2'd3, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      bus.req = k == 0 ? 4'b0010 : k == 1 ? 4'b1001 : 4'b0000;
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_drop_switch edge %0d: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask
  task automatic test_saturate();
    do_reset();
    bus.data = 4'b0000;
    for (int k = 0; k < 9; k++) begin
      bus.req = k < 7 ? 4'b0001 : 4'b0011;
      sb.push_back('{k < 7 ? 4'b0001 : 4'b0010, k < 7 ? 2'd0 : 2'd1, 1'b0, k != 0, 1'b1});
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_saturate edge %0d: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
      end
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    bus.data = 4'b0100;
    cyc();
    cyc();
    cyc();
    sb.push_back('{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0});
    #3;
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
      n_fail++;
      $display("FAIL test_async_reset mid-cycle: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want all zero",
               bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy);
    end
    cyc();
    rst = 1'b0;
    bus.req = 4'b1111;
    sb.push_back('{4'b0001, 2'd0, 1'b0, 1'b0, 1'b1});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
      n_fail++;
      $display("FAIL test_async_reset first grant: got gnt=%b sel=%0d out=%b ov=%b busy=%b, want gnt=%b sel=%0d out=%b ov=%b busy=%b",
               bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy, e.gnt, e.sel, e.out, e.ov, e.busy);
    end
  endtask
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.data = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      bus.req = k == 0 ? 4'b0001 : 4'b0011;
      bus.lock = k >= 1 && k <= 10;
      sb.push_back('{k < 14 ? 4'b0001 : 4'b0010, k < 14 ? 2'd0 : 2'd1, 1'b0, k != 0, 1'b1});
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({bus.gnt, bus.sel, bus.out, bus.out_valid, bus.busy} !== e) begin
        n_fail++;
        $display("FAIL test_lock edge %0d: got gnt=%b sel=%0d ov=%b busy=%b, want gnt=%b sel=%0d ov=%b busy=%b",
                 k, bus.gnt, bus.sel, bus.out_valid, bus.busy, e.gnt, e.sel, e.ov, e.busy);
      end
    end
    bus.lock = 1'b0;
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop_switch();
    test_saturate();
    test_async_reset();
`ifdef MUX_4_1_RR_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
